// File: rtl/matmul_pkg.sv
// matmul_pkg: FSM states, dimension helpers and operand address prefixes shared by the matmul blocks
package matmul_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_DONE} state_t;
   localparam logic [4:0] ADDR_A = 5'b00100;
   localparam logic [4:0] ADDR_B = 5'b01000;
   localparam logic [4:0] ADDR_C = 5'b10000;
   function automatic int max_dim(input int bus_w, input int data_w);
      return bus_w / data_w;
   endfunction
   function automatic int c_idx_w(input int md);
      return 2 * $clog2(md) + 1;
   endfunction
endpackage

// File: rtl/matmul_ctrl_watchdog.sv
// matmul_ctrl_watchdog: loadable up-counter that flags when LIMIT-1 is reached and then holds
module matmul_ctrl_watchdog #(
   parameter int LIMIT = 64,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             expire_o
);
   logic [WIDTH-1:0] r_cnt;
   assign expire_o = r_cnt == WIDTH'(LIMIT - 1);
   // count enabled cycles, freezing once expired so the flag stays stable
   always_ff @(posedge clk_i) begin
      if (rst_i) r_cnt <= '0;
      else if (load_i) r_cnt <= load_val_i;
      else if (en_i && !expire_o) r_cnt <= r_cnt + WIDTH'(1);
   end
endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: request sequencer for a matmul datapath; define MATMUL_CTRL_PERF_EN to add perf_cycles_o
module matmul_ctrl
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int BUS_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  req_valid_i,
   output logic                                  req_ready_o,
   input  logic [1:0]                            n_dim_i,
   input  logic [1:0]                            k_dim_i,
   input  logic [1:0]                            m_dim_i,
   input  logic                                  mode_i,
   output logic                                  calc_start_o,
   output logic [1:0]                            calc_n_o,
   output logic [1:0]                            calc_k_o,
   output logic [1:0]                            calc_m_o,
   output logic                                  calc_mode_o,
   output logic                                  rd_en_o,
   output logic [1:0]                            rd_row_a_o,
   output logic [1:0]                            rd_row_b_o,
   output logic [c_idx_w(max_dim(BUS_WIDTH, DATA_WIDTH))-1:0] rd_elem_c_o,
   input  logic                                  calc_finish_i,
   input  logic [BUS_WIDTH-1:0]                  calc_flags_i,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  timeout_o,
   output logic [BUS_WIDTH-1:0]                  flags_o
`ifdef MATMUL_CTRL_PERF_EN
   ,output logic [15:0]                          perf_cycles_o
`endif
);
   localparam int MAX_DIM = max_dim(BUS_WIDTH, DATA_WIDTH);
   localparam int CW      = c_idx_w(MAX_DIM);
   localparam int LW      = 5;
   localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);
   state_t r_state, w_next;
   logic [LW-1:0] r_ld_cnt, w_cl, w_last, w_c;
   logic r_abort, w_accept, w_expire;
   assign w_accept = req_valid_i && (r_state == ST_IDLE);
   // highest C element index for the registered shape; the load phase must also cover every A and B row
   assign w_cl   = (LW'(calc_n_o) + LW'(1)) * (LW'(calc_m_o) + LW'(1)) - LW'(1);
   assign w_last = (w_cl >= LW'(calc_n_o) && w_cl >= LW'(calc_m_o)) ? w_cl :
                   (LW'(calc_n_o) >= LW'(calc_m_o)) ? LW'(calc_n_o) : LW'(calc_m_o);
   assign w_c    = (r_ld_cnt < w_cl) ? r_ld_cnt : w_cl;
   matmul_ctrl_watchdog #(.LIMIT(TIMEOUT_CYCLES), .WIDTH(WW)) u_wdog (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_accept),
      .load_val_i ('0),
      .en_i       (r_state == ST_WAIT),
      .expire_o   (w_expire)
   );
   // next state and state-decoded outputs; indices are combinational so read data lines up with them
   always_comb begin
      w_next       = r_state;
      req_ready_o  = 1'b0;
      calc_start_o = 1'b0;
      rd_en_o      = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      timeout_o    = 1'b0;
      rd_row_a_o   = 2'd0;
      rd_row_b_o   = 2'd0;
      rd_elem_c_o  = '0;
      w_next = (r_state == ST_IDLE) ? (w_accept ? ST_LOAD : ST_IDLE) :
               (r_state == ST_LOAD) ? ((r_ld_cnt == w_last) ? ST_WAIT : ST_LOAD) :
               (r_state == ST_WAIT) ? ((calc_finish_i || w_expire) ? ST_DONE : ST_WAIT) : ST_IDLE;
      req_ready_o  = r_state == ST_IDLE;
      calc_start_o = (r_state == ST_LOAD) || (r_state == ST_WAIT);
      busy_o       = r_state != ST_IDLE;
      done_o       = r_state == ST_DONE;
      timeout_o    = (r_state == ST_DONE) && r_abort;
      rd_en_o      = r_state == ST_LOAD;
      rd_row_a_o   = !rd_en_o ? 2'd0 : (r_ld_cnt < LW'(calc_n_o)) ? r_ld_cnt[1:0] : calc_n_o;
      rd_row_b_o   = !rd_en_o ? 2'd0 : (r_ld_cnt < LW'(calc_m_o)) ? r_ld_cnt[1:0] : calc_m_o;
      rd_elem_c_o  = rd_en_o ? CW'(w_c) : '0;
   end
   // state register, request capture, load counter, finish flags and abort marker
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_ld_cnt    <= '0;
         r_abort     <= 1'b0;
         calc_n_o    <= 2'd0;
         calc_k_o    <= 2'd0;
         calc_m_o    <= 2'd0;
         calc_mode_o <= 1'b0;
         flags_o     <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            calc_n_o    <= n_dim_i;
            calc_k_o    <= k_dim_i;
            calc_m_o    <= m_dim_i;
            calc_mode_o <= mode_i;
            r_ld_cnt    <= '0;
            r_abort     <= 1'b0;
         end
         if (r_state == ST_LOAD) r_ld_cnt <= r_ld_cnt + LW'(1);
         if (r_state == ST_WAIT) begin
            if (calc_finish_i) flags_o <= calc_flags_i;
            r_abort <= !calc_finish_i && w_expire;
         end
      end
   end
`ifdef MATMUL_CTRL_PERF_EN
   logic [15:0] r_perf_cnt;
   // accept-to-done cycle count, saturating, published when DONE is reached
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_perf_cnt    <= '0;
         perf_cycles_o <= '0;
      end else begin
         if (w_accept) r_perf_cnt <= 16'd1;
         else if ((r_state == ST_LOAD || r_state == ST_WAIT) && r_perf_cnt != 16'hFFFF) r_perf_cnt <= r_perf_cnt + 16'd1;
         if (r_state == ST_DONE) perf_cycles_o <= r_perf_cnt;
      end
   end
`endif
endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: randomized self-checking bench for matmul_ctrl against an arithmetic reference model
module tb_matmul_ctrl;
   localparam int DW = 8;
   localparam int BW = 16;
   localparam int TO = 64;
   localparam int CW = 2 * $clog2(BW / DW) + 1;
   logic clk = 1'b0;
   logic rst_i, req_valid_i, req_ready_o, mode_i, calc_start_o, calc_mode_o, rd_en_o;
   logic [1:0] n_dim_i, k_dim_i, m_dim_i, calc_n_o, calc_k_o, calc_m_o, rd_row_a_o, rd_row_b_o;
   logic [CW-1:0] rd_elem_c_o;
   logic calc_finish_i, busy_o, done_o, timeout_o;
   logic [BW-1:0] calc_flags_i, flags_o;
`ifdef MATMUL_CTRL_PERF_EN
   logic [15:0] perf_cycles_o;
`endif
   int checks = 0, errors = 0, n_acc = 0, n_ops = 0;
   logic [BW-1:0] exp_flags = '0;
   always #5 clk = ~clk;
   matmul_ctrl #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i), .mode_i(mode_i),
      .calc_start_o(calc_start_o), .calc_n_o(calc_n_o), .calc_k_o(calc_k_o), .calc_m_o(calc_m_o),
      .calc_mode_o(calc_mode_o), .rd_en_o(rd_en_o), .rd_row_a_o(rd_row_a_o), .rd_row_b_o(rd_row_b_o),
      .rd_elem_c_o(rd_elem_c_o), .calc_finish_i(calc_finish_i), .calc_flags_i(calc_flags_i),
      .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .flags_o(flags_o)
`ifdef MATMUL_CTRL_PERF_EN
      , .perf_cycles_o(perf_cycles_o)
`endif
   );
   always @(posedge clk) if (!rst_i && req_valid_i && req_ready_o) n_acc++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic int min2(input int a, input int b);
      return a < b ? a : b;
   endfunction
   // one full operation; fd = WAIT cycle on which finish is driven (out of range = never)
   task automatic run_op(input int n, input int k, input int m, input int md, input int fd,
                         input logic [BW-1:0] fl, input bit hold);
      int cl, l, w, wexp;
      bit tmo;
      cl   = (n + 1) * (m + 1) - 1;
      l    = ((cl > n && cl > m) ? cl : (n > m ? n : m)) + 1;
      tmo  = !(fd >= 0 && fd < TO);
      wexp = tmo ? TO : fd + 1;
      check("idle_ready", req_ready_o, 1);
      req_valid_i = 1'b1;
      n_dim_i = 2'(n); k_dim_i = 2'(k); m_dim_i = 2'(m); mode_i = 1'(md);
      @(negedge clk);
      n_ops++;
      if (!hold) req_valid_i = 1'b0;
      n_dim_i = 2'($urandom); k_dim_i = 2'($urandom); m_dim_i = 2'($urandom); mode_i = 1'($urandom);
      for (int i = 0; i < l; i++) begin
         calc_finish_i = 1'($urandom);
         check("load_rd_en", rd_en_o, 1);
         check("load_start", calc_start_o, 1);
         check("load_ready", req_ready_o, 0);
         check("load_busy", busy_o, 1);
         check("row_a", rd_row_a_o, min2(i, n));
         check("row_b", rd_row_b_o, min2(i, m));
         check("elem_c", rd_elem_c_o, min2(i, cl) & ((1 << CW) - 1));
         check("dims", {calc_n_o, calc_k_o, calc_m_o, calc_mode_o}, {2'(n), 2'(k), 2'(m), 1'(md)});
         @(negedge clk);
      end
      calc_finish_i = 1'b0;
      check("wait_rd_en", rd_en_o, 0);
      w = 0;
      while (!done_o && w < TO + 10) begin
         check("wait_start", calc_start_o, 1);
         calc_finish_i = (w == fd);
         calc_flags_i  = (w == fd) ? fl : BW'($urandom);
         @(negedge clk);
         w++;
      end
      calc_finish_i = 1'b0;
      check("wait_len", w, wexp);
      check("done", done_o, 1);
      check("timeout", timeout_o, 32'(tmo));
      check("done_start", calc_start_o, 0);
      check("done_busy", busy_o, 1);
      if (!tmo) exp_flags = fl;
      check("flags", flags_o, exp_flags);
      @(negedge clk);
      check("post_done", done_o, 0);
      check("post_busy", busy_o, 0);
      check("post_ready", req_ready_o, 1);
`ifdef MATMUL_CTRL_PERF_EN
      check("perf", perf_cycles_o, l + wexp + 1);
`endif
   endtask
   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; n_dim_i = '0; k_dim_i = '0; m_dim_i = '0; mode_i = 1'b0;
      calc_finish_i = 1'b0; calc_flags_i = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", req_ready_o, 1);
      check("rst_outs", {calc_start_o, rd_en_o, busy_o, done_o, timeout_o}, 0);
      check("rst_flags", flags_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      run_op(1, 1, 1, 1, 5, 16'hA5C3, 1'b0);
      run_op(0, 0, 0, 0, 2, 16'h0001, 1'b0);
      run_op(1, 0, 1, 0, -1, 16'h7777, 1'b0);
      run_op(0, 1, 1, 1, TO - 1, 16'h1234, 1'b0);
      for (int j = 0; j < 3; j++) run_op(int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 3)), 0, j, BW'($urandom), 1'b1);
      req_valid_i = 1'b0;
      check("accept_count", n_acc, n_ops);
      @(negedge clk);
      for (int j = 0; j < 20; j++) begin
         int sel, fd;
         sel = int'($urandom_range(0, 9));
         fd  = sel == 0 ? -1 : sel == 1 ? TO - 1 : sel == 2 ? TO : int'($urandom_range(0, 12));
         run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), fd, BW'($urandom), 1'($urandom));
         req_valid_i = 1'b0;
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      check("accept_count2", n_acc, n_ops);
      req_valid_i = 1'b1; n_dim_i = 2'd1; m_dim_i = 2'd0;
      @(negedge clk);
      req_valid_i = 1'b0;
      repeat (2 + 4) @(negedge clk);
      check("mid_wait_start", calc_start_o, 1);
      rst_i = 1'b1;
      @(negedge clk);
      check("rst_start", calc_start_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_ready2", req_ready_o, 1);
      check("rst_flags2", flags_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
